// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader sits on the slave side; the byte source / memory model on master.
interface boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/boot_loader.sv
// Serial boot loader: receives a framed byte stream (A5, count, payload,
// XOR checksum), writes 32-bit words into instruction memory and releases
// the CPU from reset once a frame with a good checksum has been loaded.
module boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic           clk,
  input  logic           reset,
  boot_loader_if.slave   bus,
  input  logic           restart,
  output logic           cpu_reset,
  output logic           done,
  output logic           error
);

  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR} state_t;

  // Largest loadable frame is a full memory image.
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;
  localparam logic [7:0]  HDR   = 8'hA5;

  state_t            state;
  logic [7:0]        cnt_hi;
  logic [7:0]        csum;
  logic [1:0]        bcnt;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] wlast;
  logic [23:0]       asm_q;   // first three bytes of the word being built
  logic              accept;
  logic [15:0]       n;

  assign accept = bus.rx_valid && bus.rx_ready;
  assign n      = {cnt_hi, bus.rx_data};

  // Frame FSM; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bus.rx_ready <= 1'b1;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      cnt_hi       <= '0;
      csum         <= '0;
      bcnt         <= '0;
      widx         <= '0;
      wlast        <= '0;
      asm_q        <= '0;
    end else begin
      bus.im_we <= 1'b0;
      case (state)
        IDLE: if (accept && bus.rx_data == HDR) begin
          // Fresh frame: clear per-frame accumulators.
          state <= CNT_HI;
          csum  <= '0;
          bcnt  <= '0;
          widx  <= '0;
        end
        CNT_HI: if (accept) begin
          cnt_hi <= bus.rx_data;
          state  <= CNT_LO;
        end
        CNT_LO: if (accept) begin
          // Only meaningful when 0 < n <= MAX_N, so truncation is safe there.
          wlast <= ADDR_W'(n - 16'd1);
          if (n == 16'd0) begin
            state <= CSUM;
          end else if ({1'b0, n} > MAX_N) begin
            state        <= ERR;
            error        <= 1'b1;
            bus.rx_ready <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          asm_q <= {asm_q[15:0], bus.rx_data};
          csum  <= csum ^ bus.rx_data;
          bcnt  <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            bus.im_we    <= 1'b1;
            bus.im_wdata <= {asm_q, bus.rx_data};
            bus.im_addr  <= widx;
            widx         <= widx + 1'b1;
            // Move on while the last write is still in flight: no rx bubble.
            if (widx == wlast) state <= CSUM;
          end
        end
        CSUM: if (accept) begin
          bus.rx_ready <= 1'b0;
          if (bus.rx_data == csum) begin
            state     <= DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
        DONE, ERR: if (restart) begin
          state        <= IDLE;
          bus.rx_ready <= 1'b1;
          done         <= 1'b0;
          error        <= 1'b0;
          cpu_reset    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: good frame, bad checksum, resync, oversize,
// stalled stream and mid-frame reset.
module tb_boot_loader;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic restart = 1'b0;
  logic cpu_reset, done, error;

  boot_loader_if #(.ADDR_W(ADDR_W)) bif();

  boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif.slave),
    .restart   (restart),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];

  // Capture every memory write strobe.
  always @(negedge clk) begin
    if (bif.im_we === 1'b1) begin
      wq_addr.push_back(bif.im_addr);
      wq_data.push_back(bif.im_wdata);
    end
  end

  logic [7:0] frame_a[12] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56,
                              8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};

  // Entered and left at a negedge; byte accepted at the posedge in between.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tmo;
    bif.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bif.rx_valid = 1'b1;
    bif.rx_data  = b;
    tmo = 0;
    while (bif.rx_ready !== 1'b1 && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL send_byte timeout: rx_ready=%b for byte %h, required 1", bif.rx_ready, b);
    end
    @(negedge clk);
    bif.rx_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++; if (bif.rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", bif.rx_ready); end
    n_cmp++; if (bif.im_we !== 1'b0) begin n_err++; $display("FAIL reset_im_we: got %b want 0", bif.im_we); end
    n_cmp++; if (bif.im_addr !== '0) begin n_err++; $display("FAIL reset_im_addr: got %h want 0", bif.im_addr); end
    n_cmp++; if (bif.im_wdata !== 32'h0) begin n_err++; $display("FAIL reset_im_wdata: got %h want 0", bif.im_wdata); end
    n_cmp++; if ({cpu_reset, done, error} !== 3'b100) begin n_err++; $display("FAIL reset_flags: got cpu_reset/done/error=%b want 100", {cpu_reset, done, error}); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Sends frame_a with a fixed gap before each byte and checks the result.
  task automatic test_good_frame(input string tag, input int gap);
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 12; i++) send_byte(frame_a[i], gap);
    n_cmp++; if (wq_addr.size() !== 2) begin n_err++; $display("FAIL %s_nwrites: got %0d want 2", tag, wq_addr.size()); end
    else begin
      n_cmp++; if (wq_addr[0] !== 10'd0 || wq_data[0] !== 32'h12345678) begin n_err++; $display("FAIL %s_w0: got %h/%h want 000/12345678", tag, wq_addr[0], wq_data[0]); end
      n_cmp++; if (wq_addr[1] !== 10'd1 || wq_data[1] !== 32'h9ABCDEF0) begin n_err++; $display("FAIL %s_w1: got %h/%h want 001/9abcdef0", tag, wq_addr[1], wq_data[1]); end
    end
    n_cmp++; if ({done, cpu_reset, error, bif.rx_ready} !== 4'b1000) begin n_err++; $display("FAIL %s_done: got done/cpu_reset/error/rx_ready=%b want 1000", tag, {done, cpu_reset, error, bif.rx_ready}); end
    n_cmp++; if (bif.im_addr !== 10'd1 || bif.im_wdata !== 32'h9ABCDEF0) begin n_err++; $display("FAIL %s_hold: got %h/%h want 001/9abcdef0", tag, bif.im_addr, bif.im_wdata); end
    pulse_restart();
    n_cmp++; if ({done, cpu_reset, bif.rx_ready} !== 3'b011) begin n_err++; $display("FAIL %s_restart: got done/cpu_reset/rx_ready=%b want 011", tag, {done, cpu_reset, bif.rx_ready}); end
  endtask

  task automatic test_bad_csum();
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 11; i++) send_byte(frame_a[i], 0);
    send_byte(8'h01, 0);
    n_cmp++; if (wq_addr.size() !== 2) begin n_err++; $display("FAIL badcs_nwrites: got %0d want 2", wq_addr.size()); end
    n_cmp++; if ({error, done, cpu_reset, bif.rx_ready} !== 4'b1010) begin n_err++; $display("FAIL badcs_err: got error/done/cpu_reset/rx_ready=%b want 1010", {error, done, cpu_reset, bif.rx_ready}); end
    // Must stay in ERR without restart.
    repeat (3) @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL badcs_sticky: got %b want 1", error); end
    pulse_restart();
    n_cmp++; if ({error, cpu_reset, bif.rx_ready} !== 3'b011) begin n_err++; $display("FAIL badcs_restart: got error/cpu_reset/rx_ready=%b want 011", {error, cpu_reset, bif.rx_ready}); end
  endtask

  task automatic test_resync();
    logic [7:0] s[6] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    wq_addr.delete(); wq_data.delete();
    // Restart outside DONE/ERR must be ignored.
    restart = 1'b1;
    send_byte(s[0], 0);
    restart = 1'b0;
    for (int i = 1; i < 6; i++) send_byte(s[i], 0);
    n_cmp++; if (wq_addr.size() !== 0) begin n_err++; $display("FAIL resync_nwrites: got %0d want 0", wq_addr.size()); end
    n_cmp++; if ({done, error, cpu_reset} !== 3'b100) begin n_err++; $display("FAIL resync_done: got done/error/cpu_reset=%b want 100", {done, error, cpu_reset}); end
    pulse_restart();
  endtask

  task automatic test_oversize();
    wq_addr.delete(); wq_data.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    n_cmp++; if ({error, done, cpu_reset, bif.rx_ready} !== 4'b1010) begin n_err++; $display("FAIL oversize_err: got error/done/cpu_reset/rx_ready=%b want 1010", {error, done, cpu_reset, bif.rx_ready}); end
    n_cmp++; if (wq_addr.size() !== 0) begin n_err++; $display("FAIL oversize_nwrites: got %0d want 0", wq_addr.size()); end
    pulse_restart();
    // Exactly 2^ADDR_W words is still legal: must enter DATA, not ERR.
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL maxsize_err: got %b want 0", error); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) send_byte(frame_a[i], 0);
    reset = 1'b0;
    #1;
    n_cmp++; if (bif.im_wdata !== 32'h0 || bif.im_addr !== '0 || bif.im_we !== 1'b0) begin n_err++; $display("FAIL midrst_bus: got we/addr/wdata=%b/%h/%h want 0/000/00000000", bif.im_we, bif.im_addr, bif.im_wdata); end
    n_cmp++; if ({bif.rx_ready, cpu_reset, done, error} !== 4'b1100) begin n_err++; $display("FAIL midrst_flags: got rx_ready/cpu_reset/done/error=%b want 1100", {bif.rx_ready, cpu_reset, done, error}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // Leftover payload bytes must be dropped while hunting for a header.
    send_byte(8'hBC, 0);
    send_byte(8'hDE, 0);
    test_good_frame("midrst", 0);
  endtask

  initial begin
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    test_reset();
    test_good_frame("good", 0);
    test_bad_csum();
    test_resync();
    test_oversize();
    test_good_frame("stall", 3);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_valid  input  1  byte-stream source has a byte on rx_data.
REQ-005 SHALL have port rx_data  input  8  incoming byte.
REQ-006 SHALL have port rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at a rising edge.
REQ-007 SHALL have port restart  input  1  return from DONE/ERR to IDLE.
REQ-008 SHALL have port im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port im_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port im_wdata  output  32  instruction word to write.
REQ-011 SHALL have port cpu_reset  output  1  active-high reset to the CPU; held high until a load completes.
REQ-012 SHALL have port done  output  1  load completed with good checksum.
REQ-013 SHALL have port error  output  1  load aborted (checksum mismatch or oversize count).

Function
REQ-014 SHALL implement the frame: header 0xA5; count_hi; count_lo (16-bit word count N, MSB first); N*4 payload bytes, each word MSB byte first; one checksum byte equal to the XOR of all payload bytes.
REQ-015 SHALL implement states IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR.
REQ-016 SHALL assert rx_ready in IDLE, CNT_HI, CNT_LO, DATA, CSUM; deassert it in DONE and ERR.
REQ-017 IDLE: accepted byte 0xA5 -> CNT_HI; any other accepted byte is discarded, remain in IDLE (resync).
REQ-018 CNT_HI -> CNT_LO on accepted byte; CNT_LO -> DATA on accepted byte if 0 < N <= 2^ADDR_W, -> CSUM if N == 0, -> ERR if N > 2^ADDR_W.
REQ-019 DATA: shift accepted bytes into a 32-bit assembly register; XOR each into the running checksum; a 2-bit byte counter wraps 3 -> 0.
REQ-020 On acceptance of the 4th byte of a word, im_we SHALL be 1 on the next cycle only, with im_wdata = assembled word and im_addr = word index (0 for first word, incrementing by 1).
REQ-021 After the write of word N-1 is scheduled, transition to CSUM; rx_ready stays 1 (no bubble).
REQ-022 CSUM: accepted byte equal to running checksum -> DONE, else -> ERR; running checksum is 0 when N == 0.
REQ-023 No state advance or byte consumption SHALL occur in a cycle with rx_valid == 0; stalls of any length are permitted mid-word.
REQ-024 cpu_reset SHALL be 1 in all states except DONE; it SHALL drop to 0 on the cycle the FSM enters DONE.
REQ-025 done = 1 only in DONE; error = 1 only in ERR; both registered.
REQ-026 restart == 1 in DONE or ERR -> IDLE next cycle, reasserting cpu_reset; restart is ignored in other states.
REQ-027 Memory words already written before an ERR SHALL NOT be rolled back; cpu_reset remains 1.
REQ-028 im_addr and im_wdata SHALL hold their last values while im_we == 0.

Reset
REQ-029 reset == 0 SHALL immediately force state IDLE, rx_ready 1, im_we 0, im_addr 0, im_wdata 0, cpu_reset 1, done 0, error 0, checksum 0, byte counter 0, word index 0.
REQ-030 reset asserted mid-frame SHALL abandon the frame; after release the loader SHALL wait for a new 0xA5 header.

Verification
REQ-031 Bytes A5 00 02 12 34 56 78 9A BC DE F0 00 (XOR of payload = 0x00) -> im_we pulses: addr 0 data 0x12345678, addr 1 data 0x9ABCDEF0; done=1, cpu_reset=0, error=0.
REQ-032 Same frame with checksum byte 0x01 -> two writes occur, then error=1, done=0, cpu_reset=1, rx_ready=0; restart=1 for one cycle -> IDLE, error=0.
REQ-033 Bytes 00 FF A5 00 00 00 -> leading 00 FF discarded, no im_we, done=1 after final byte.
REQ-034 With ADDR_W=10, header A5 04 01 (N=1025) -> ERR on count_lo acceptance, no im_we.
REQ-035 Frame of REQ-031 with rx_valid low for 3 random cycles between every byte -> identical writes and done result.
REQ-036 reset pulsed low after 5 payload bytes of REQ-031 frame, then full REQ-031 frame resent -> all outputs at reset values during reset; final writes and done exactly as REQ-031.
